// File: rtl/lut_reader.sv
// lut_reader
//   Read-side client of the 256 x 12 color LUT. Palette indices come in on a
//   valid/ready stream, are sent straight to the LUT read address, and the
//   registered read data returns one cycle later. A 3-entry FIFO absorbs that
//   latency so the output stream can be stalled at any time without losing or
//   reordering colors. Entries equal to 12'h000 are the not-valid-pixel
//   marker; they are flagged on the output and counted (saturating).
//
// Ports
//   clk, rst_n             block clock (also LUT rd_clk), async active-low reset
//   idx_valid/idx_ready    index stream handshake
//   idx_data, idx_last     palette index and end-of-line marker
//   rd_add                 LUT read address (combinational copy of idx_data)
//   rd_data                LUT registered read data
//   px_valid/px_ready      color stream handshake
//   px_data, px_invalid    color and its not-valid flag (px_data == 0)
//   px_last                idx_last that travelled with the index
//   invalid_cnt            saturating count of not-valid pixels delivered

module lut_reader #(
  parameter int ram_width  = 8,
  parameter int data_width = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idx_valid,
  output logic                  idx_ready,
  input  logic [ram_width-1:0]  idx_data,
  input  logic                  idx_last,
  output logic [ram_width-1:0]  rd_add,
  input  logic [data_width-1:0] rd_data,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic [data_width-1:0] px_data,
  output logic                  px_invalid,
  output logic                  px_last,
  output logic [15:0]           invalid_cnt
);

  logic                  inflight;
  logic                  inflight_last;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            count;
  logic [data_width-1:0] fifo_data [0:2];
  logic                  fifo_inv  [0:2];
  logic                  fifo_last [0:2];

  logic accept;
  logic push;
  logic pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // The LUT samples the address every edge; only accepted indices matter.
  assign rd_add = idx_data;

  // Reserve a FIFO slot for the read already in flight, so a push can never
  // find the FIFO full. Depends only on registers: no px_ready feed-through.
  assign idx_ready = ({1'b0, count} + {2'b00, inflight}) < 3'd3;

  assign accept = idx_valid && idx_ready;
  assign push   = inflight;
  assign pop    = px_valid && px_ready;

  assign px_valid   = (count != 2'd0);
  assign px_data    = fifo_data[rd_ptr];
  assign px_invalid = fifo_inv[rd_ptr];
  assign px_last    = fifo_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_last <= idx_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        fifo_data[i] <= '0;
        fifo_inv[i]  <= 1'b0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr <= 2'd0;
    end else if (push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_inv[wr_ptr]  <= (rd_data == '0);
      fifo_last[wr_ptr] <= inflight_last;
      wr_ptr            <= ptr_inc(wr_ptr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
    end else if (pop) begin
      rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invalid_cnt <= 16'h0000;
    end else if (pop && px_invalid && (invalid_cnt != 16'hFFFF)) begin
      invalid_cnt <= invalid_cnt + 16'd1;
    end
  end

  // The ready rule guarantees a returning read always has a free slot.
  always @(posedge clk) begin
    if (rst_n && push) begin
      assert (count != 2'd3);
    end
  end

endmodule

// File: tb/tb_lut_reader.sv
// Directed and randomized checks for lut_reader against a behavioural LUT.

module tb_lut_reader;

  localparam int RW = 8;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          idx_valid = 1'b0;
  logic          idx_ready;
  logic [RW-1:0] idx_data = '0;
  logic          idx_last = 1'b0;
  logic [RW-1:0] rd_add;
  logic [DW-1:0] rd_data = '0;
  logic          px_valid;
  logic          px_ready = 1'b0;
  logic [DW-1:0] px_data;
  logic          px_invalid;
  logic          px_last;
  logic [15:0]   invalid_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  lut_reader #(.ram_width(RW), .data_width(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_valid   (idx_valid),
    .idx_ready   (idx_ready),
    .idx_data    (idx_data),
    .idx_last    (idx_last),
    .rd_add      (rd_add),
    .rd_data     (rd_data),
    .px_valid    (px_valid),
    .px_ready    (px_ready),
    .px_data     (px_data),
    .px_invalid  (px_invalid),
    .px_last     (px_last),
    .invalid_cnt (invalid_cnt)
  );

  always #5 clk = ~clk;

  // Default LUT: identity, except four entries cleared to the not-valid color.
  function automatic logic [DW-1:0] lut_exp(input int i);
    if (i == 4 || i == 51 || i == 53 || i == 103) return '0;
    return DW'(i);
  endfunction

  logic [DW-1:0] lut_mem [256];
  initial for (int i = 0; i < 256; i++) lut_mem[i] = lut_exp(i);

  always_ff @(posedge clk) rd_data <= lut_mem[rd_add];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    idx_valid = 1'b0;
    idx_data  = '0;
    idx_last  = 1'b0;
    px_ready  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int sent, got, cyc, first_acc, first_out, acc;
    int bp_idx [4];
    logic [12:0] sb [$];
    logic [12:0] exp_e;
    logic [13:0] prev_px;
    logic        prev_stall;

    // ---------------- reset defaults
    do_reset();
    check_val("rst_px_valid", px_valid, 0);
    check_val("rst_idx_ready", idx_ready, 1);
    check_val("rst_invalid_cnt", invalid_cnt, 0);
    check_val("rst_px_data", px_data, 0);
    check_val("rst_px_last", px_last, 0);
    check_val("rst_px_invalid", px_invalid, 0);

    // ---------------- full stream 0..255
    sent = 0; got = 0; cyc = 0; first_acc = -1; first_out = -1;
    while (got < 256 && cyc < 400) begin
      @(negedge clk);
      idx_valid = (sent < 256);
      idx_data  = sent[7:0];
      idx_last  = (sent == 255);
      px_ready  = 1'b1;
      #1;
      if (px_valid) begin
        if (first_out < 0) first_out = cyc;
        check_val("stream_gap", cyc - first_out, got);
        check_val("stream_data", px_data, lut_exp(got));
        check_val("stream_invalid", px_invalid, (got == 0 || got == 4 || got == 51 || got == 53 || got == 103));
        check_val("stream_last", px_last, (got == 255));
        got++;
      end
      if (idx_valid && idx_ready) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      cyc++;
    end
    check_val("stream_count", got, 256);
    check_val("stream_latency", first_out - first_acc, 2);
    @(negedge clk);
    idx_valid = 1'b0;
    idx_last  = 1'b0;
    #1;
    check_val("stream_invalid_cnt", invalid_cnt, 5);
    check_val("stream_drained", px_valid, 0);

    // ---------------- backpressure
    bp_idx = '{5, 6, 7, 8};
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      px_ready  = 1'b0;
      idx_valid = 1'b1;
      idx_data  = RW'(bp_idx[(acc < 4) ? acc : 3]);
      #1;
      if (idx_valid && idx_ready) acc++;
    end
    check_val("bp_accepted", acc, 3);
    check_val("bp_ready_low", idx_ready, 0);
    check_val("bp_head", px_data, 12'h005);
    got = 0; first_out = -1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      @(negedge clk);
      px_ready  = 1'b1;
      idx_valid = (acc < 4);
      idx_data  = RW'(bp_idx[(acc < 4) ? acc : 3]);
      #1;
      if (c == 0) check_val("bp_ready_at_first_pop", idx_ready, 0);
      if (c == 1) check_val("bp_ready_after_pop", idx_ready, 1);
      if (px_valid) begin
        if (first_out < 0) first_out = c;
        check_val("bp_gap", c - first_out, got);
        check_val("bp_data", px_data, DW'(bp_idx[got]));
        got++;
      end
      if (idx_valid && idx_ready) acc++;
    end
    check_val("bp_outputs", got, 4);
    @(negedge clk);
    idx_valid = 1'b0;

    // ---------------- reset mid-stream
    repeat (3) @(negedge clk);
    px_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      idx_valid = 1'b1;
      idx_data  = RW'(c + 1);
      #1;
      if (idx_valid && idx_ready) acc++;
      @(negedge clk);
    end
    idx_valid = 1'b0;
    #1;
    check_val("mid_accepted", acc, 3);
    check_val("mid_count", dut.count, 2);
    check_val("mid_inflight", dut.inflight, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_px_valid", px_valid, 0);
    check_val("mid_rst_idx_ready", idx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idx_valid = 1'b1;
    idx_data  = 8'd9;
    px_ready  = 1'b1;
    #1;
    check_val("mid_accept9", idx_ready, 1);
    @(negedge clk);
    idx_valid = 1'b0;
    #1;
    check_val("mid_lat1_px_valid", px_valid, 0);
    @(negedge clk);
    #1;
    check_val("mid_lat2_px_valid", px_valid, 1);
    check_val("mid_lat2_px_data", px_data, 12'h009);
    @(negedge clk);
    #1;
    check_val("mid_after_px_valid", px_valid, 0);

    // ---------------- random handshakes
    do_reset();
    sent = 0; got = 0; cyc = 0;
    prev_stall = 1'b0;
    prev_px = '0;
    while (got < 10000 && cyc < 60000) begin
      @(negedge clk);
      idx_valid = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      idx_data  = RW'($urandom_range(0, 255));
      idx_last  = 1'($urandom_range(0, 1));
      px_ready  = 1'($urandom_range(0, 1));
      #1;
      check_val("rand_occupancy", (int'(dut.count) + int'(dut.inflight)) <= 3, 1);
      if (prev_stall) begin
        check_val("rand_stall_valid", px_valid, 1);
        check_val("rand_stall_stable", {px_data, px_invalid, px_last}, prev_px);
      end
      if (px_valid && px_ready) begin
        if (sb.size() == 0) begin
          check_val("rand_underflow", 1, 0);
        end else begin
          exp_e = sb.pop_front();
          check_val("rand_data_last", {px_last, px_data}, exp_e);
          check_val("rand_invalid", px_invalid, (exp_e[11:0] == 12'h000));
        end
        got++;
      end
      if (idx_valid && idx_ready) begin
        sb.push_back({idx_last, lut_exp(int'(idx_data))});
        sent++;
      end
      prev_stall = px_valid && !px_ready;
      prev_px    = {px_data, px_invalid, px_last};
      cyc++;
    end
    check_val("rand_delivered", got, 10000);
    check_val("rand_sb_empty", sb.size(), 0);

    // ---------------- counter saturation
    do_reset();
    force dut.invalid_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.invalid_cnt;
    #1;
    check_val("sat_preset", invalid_cnt, 16'hFFFE);
    bp_idx = '{0, 4, 51, 103};
    acc = 0; got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      px_ready  = 1'b1;
      idx_valid = (acc < 3);
      idx_data  = RW'(bp_idx[(acc < 3) ? acc : 3]);
      #1;
      if (px_valid) begin
        if (got == 1) check_val("sat_reached", invalid_cnt, 16'hFFFF);
        got++;
      end
      if (idx_valid && idx_ready) acc++;
    end
    idx_valid = 1'b0;
    check_val("sat_outputs", got, 3);
    check_val("sat_final", invalid_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_reader.md
# lut_reader

Read-side client of the dual-clock color LUT RAM (256 × 12, one-cycle registered read). It accepts a stream of palette indices with valid/ready handshake, drives the RAM read address, and returns the looked-up 12-bit colors in order on a valid/ready output stream. It absorbs the RAM's fixed read latency under arbitrary output backpressure. It flags entries holding 12'h000, the team's not-valid-pixel marker. It sits between the pixel-index generator and the video output stage, on the LUT `rd_clk` domain.

## Interface
- `ram_width`, 8: LUT address width; index width.
- `data_width`, 12: LUT word / color width.
- `clk` in 1: block clock; also drives the LUT `rd_clk`.
- `rst_n` in 1: asynchronous active-low reset.
- `idx_valid` in 1: input index valid.
- `idx_ready` out 1: input index ready.
- `idx_data` in `ram_width`: palette index.
- `idx_last` in 1: end-of-line marker, travels with the index.
- `rd_add` out `ram_width`: LUT read address.
- `rd_data` in `data_width`: LUT registered read data.
- `px_valid` out 1: output color valid.
- `px_ready` in 1: downstream ready.
- `px_data` out `data_width`: color.
- `px_invalid` out 1: `px_data` == 0 (not-valid pixel).
- `px_last` out 1: `idx_last` of the corresponding index.
- `invalid_cnt` out 16: count of not-valid pixels delivered. Saturates at 16'hFFFF.

## Operation
- **rd_add:** `rd_add` = `idx_data`, combinational. The LUT samples it at each `clk` edge. Data is meaningful only when an index is accepted (`idx_valid && idx_ready`).
- **Read tracking:** on acceptance, set `inflight`=1 and register `idx_last` into `inflight_last`. Otherwise `inflight`=0.
- **Capture:** when `inflight`=1, in the following cycle push {`rd_data`==0, `rd_data`, `inflight_last`} into a 3-entry FIFO.
- **Ready rule:** `idx_ready` = (`count` + `inflight`) < 3. `count` is the FIFO occupancy, 0..3. There is no combinational path from `px_ready` to `idx_ready`.
- **Output:** `px_valid` = (`count` != 0). `px_data`, `px_invalid` and `px_last` come from the FIFO head. Pop when `px_valid && px_ready`.
- **Counter:** `invalid_cnt` increments on each pop with `px_invalid`=1. It holds at 16'hFFFF.
- **Flag semantics:** index 0 also maps to 12'h000 and is flagged. This is intended: color 0 is reserved.
- **FIFO pointers:** 2-bit read/write pointers wrap 2→0.
- **Simultaneous push and pop:** `count` is unchanged.
- **Full FIFO:** push with `count`=3 is impossible by the ready rule. Assert this in simulation.
- **Ordering:** strictly in order. No drop, no duplicate.
- **LUT writes:** write-side writes to the LUT during reads are not this block's concern. The returned data is whatever the RAM registers.

## Timing
- **Reset values** (async, on `rst_n` low): `inflight`=0, `count`=0, pointers=0, `invalid_cnt`=0. Therefore `px_valid`=0 and `idx_ready`=1. `px_data`, `px_invalid` and `px_last` are 0 from the cleared FIFO storage.
- **Reset mid-stream:** all pending reads and FIFO contents are discarded immediately. The first transfer after release restarts cleanly.
- **Latency:** index accepted at edge t → RAM data valid in cycle t+1 → FIFO push at edge t+1 → `px_valid`=1 in cycle t+2 when the FIFO was empty. Minimum latency is 2 cycles.
- **Throughput:** 1 index/cycle sustained with `px_ready`=1. In steady state `count`=1 and `inflight`=1.
- **Backpressure:** with `px_ready`=0, at most 3 indices are accepted before `idx_ready` falls. `idx_ready` rises the cycle after the first pop.
- **Output stability:** `px_*` outputs are stable while `px_valid && !px_ready`.

## Test plan
- **Reset defaults:** after reset, check `px_valid`=0, `idx_ready`=1, `invalid_cnt`=0.
- **Stream:** with `px_ready`=1 and default LUT contents, stream indices 0..255 back-to-back with `idx_last` on 255. Require:
  - exactly 256 outputs in order, 1 per cycle after 2-cycle latency;
  - `px_data`=index except indices 4, 51, 53, 103 → 12'h000;
  - `px_invalid` on indices 0, 4, 51, 53, 103;
  - `px_last` only on the final output;
  - `invalid_cnt`=5.
- **Backpressure:** hold `px_ready`=0 and offer indices 5, 6, 7, 8 continuously. Require 5, 6, 7 accepted, then `idx_ready`=0 with 8 pending. Raise `px_ready`. Require outputs 12'h005, 12'h006, 12'h007, 12'h008 with no gaps after the first.
- **Random handshakes:** randomize `idx_valid` and `px_ready` at 50% over 10k indices. Scoreboard against a LUT model. Check: no loss or reorder, `count` ≤ 3, outputs stable while stalled.
- **Reset mid-stream:** assert `rst_n` low for 1 cycle with `count`=2 and `inflight`=1. Require `px_valid`=0 immediately. Require the next index 9 to return 12'h009 with 2-cycle latency.
- **Counter saturation:** force `invalid_cnt` to 16'hFFFE, then deliver 3 not-valid pixels. Require the counter to end at 16'hFFFF.
